// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared owner codes, FSM state type and default address width for the RAM arbiter.
package ram_arbiter_pkg;
    localparam int ADDR_W_DFLT = 25;
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_VID  = 2'd1;
    localparam logic [1:0] OWN_DSK  = 2'd2;
    localparam logic [1:0] OWN_CPU  = 2'd3;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester and SDRAM-engine signals of the RAM arbiter.
//   vid_*  : video fetch (read only)         dsk_* : disk copy DMA
//   cpu_*  : CPU wishbone master             mem_* : SDRAM command engine
//   busy   : transaction in flight           owner : current grant (0 none, 1 vid, 2 dsk, 3 cpu)
//   slave modport is the arbiter side, master modport is the surrounding system.
interface ram_arbiter_if #(
    parameter int ADDR_W = ram_arbiter_pkg::ADDR_W_DFLT
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;
    logic [15:0]       vid_rdata;
    logic              dsk_req;
    logic              dsk_we;
    logic [ADDR_W-1:0] dsk_addr;
    logic [15:0]       dsk_wdata;
    logic              dsk_ack;
    logic [15:0]       dsk_rdata;
    logic              cpu_stb;
    logic              cpu_we;
    logic [1:0]        cpu_sel;
    logic [ADDR_W-1:0] cpu_addr;
    logic [15:0]       cpu_wdata;
    logic              cpu_ack;
    logic [15:0]       cpu_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_ack;
    logic              busy;
    logic [1:0]        owner;

    modport slave (
        input  vid_req, vid_addr, dsk_req, dsk_we, dsk_addr, dsk_wdata,
               cpu_stb, cpu_we, cpu_sel, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        output vid_ack, vid_rdata, dsk_ack, dsk_rdata, cpu_ack, cpu_rdata,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy, owner
    );

    modport master (
        output vid_req, vid_addr, dsk_req, dsk_we, dsk_addr, dsk_wdata,
               cpu_stb, cpu_we, cpu_sel, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        input  vid_ack, vid_rdata, dsk_ack, dsk_rdata, cpu_ack, cpu_rdata,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy, owner
    );
endinterface

// File: rtl/ram_arbiter_pick.sv
// ram_arbiter_pick: combinational winner selection, vid > dsk > cpu with a forced CPU slot after a disk burst.
//   i_vid_req, i_dsk_req, i_cpu_stb : pending requests
//   i_dsk_run                       : back-to-back disk grants so far
//   o_win                           : winner owner code (OWN_NONE when nothing is pending)
module ram_arbiter_pick
    import ram_arbiter_pkg::*;
#(
    parameter int DSK_BURST = 8,
    parameter int RUN_W     = 4
) (
    input  logic             i_vid_req,
    input  logic             i_dsk_req,
    input  logic             i_cpu_stb,
    input  logic [RUN_W-1:0] i_dsk_run,
    output logic [1:0]       o_win
);
    logic w_cpu_forced;

    // A waiting CPU takes the slot once disk has used up its burst allowance.
    assign w_cpu_forced = i_cpu_stb && i_dsk_run == RUN_W'(DSK_BURST);

    always_comb begin
        o_win = i_vid_req                    ? OWN_VID :
                i_dsk_req && !w_cpu_forced   ? OWN_DSK :
                i_cpu_stb                    ? OWN_CPU : OWN_NONE;
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single SDRAM engine port between video, disk copy DMA and CPU, one transaction at a time.
//   clk   : system clock          reset : synchronous, active-high
//   bus   : ram_arbiter_if.slave (requester ports, SDRAM engine ports, busy, owner)
//   timeout_err : sticky mem_ack timeout flag, present only with RAM_ARBITER_TIMEOUT_EN defined
// Optional feature macro: RAM_ARBITER_TIMEOUT_EN (WAIT gives up after TIMEOUT cycles, returns 16'hFFFF).
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DFLT,
    parameter int DSK_BURST = 8
`ifdef RAM_ARBITER_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 255
`endif
) (
    input  logic         clk,
    input  logic         reset,
    ram_arbiter_if.slave bus
`ifdef RAM_ARBITER_TIMEOUT_EN
    ,
    output logic         timeout_err
`endif
);
    localparam int RUN_W = $clog2(DSK_BURST + 1);

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_owner;
    logic [1:0]        w_win;
    logic [RUN_W-1:0]  r_dsk_run;
    logic              r_we;
    logic [1:0]        r_be;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wdata;
    logic [15:0]       r_vid_rdata;
    logic [15:0]       r_dsk_rdata;
    logic [15:0]       r_cpu_rdata;
    logic [15:0]       w_rdata;
    logic              w_grant;
    logic              w_done;

    ram_arbiter_pick #(
        .DSK_BURST(DSK_BURST),
        .RUN_W    (RUN_W)
    ) u_pick (
        .i_vid_req(bus.vid_req),
        .i_dsk_req(bus.dsk_req),
        .i_cpu_stb(bus.cpu_stb),
        .i_dsk_run(r_dsk_run),
        .o_win    (w_win)
    );

    assign w_grant = r_state == IDLE && w_win != OWN_NONE;

`ifdef RAM_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout_err;
    logic             w_to;

    // r_cnt counts WAIT cycles already spent, so this fires on the TIMEOUT-th WAIT cycle.
    assign w_to    = r_state == WAIT && !bus.mem_ack && r_cnt == CNT_W'(TIMEOUT - 1);
    assign w_done  = bus.mem_ack || w_to;
    assign w_rdata = bus.mem_ack ? bus.mem_rdata : 16'hFFFF;
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_cnt         <= r_state == WAIT ? r_cnt + 1'b1 : '0;
            r_timeout_err <= r_timeout_err | w_to;
        end
    end
`else
    assign w_done  = bus.mem_ack;
    assign w_rdata = bus.mem_rdata;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state == IDLE  ? (w_grant ? ISSUE : IDLE) :
                 r_state == ISSUE ? WAIT :
                 r_state == WAIT  ? (w_done ? RESP : WAIT) : IDLE;
    end

    always_comb begin
        bus.mem_req = r_state == ISSUE;
        bus.busy    = r_state != IDLE;
        bus.vid_ack = r_state == RESP && r_owner == OWN_VID;
        bus.dsk_ack = r_state == RESP && r_owner == OWN_DSK;
        bus.cpu_ack = r_state == RESP && r_owner == OWN_CPU;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner     <= OWN_NONE;
            r_dsk_run   <= '0;
            r_we        <= 1'b0;
            r_be        <= 2'b00;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_vid_rdata <= '0;
            r_dsk_rdata <= '0;
            r_cpu_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_owner <= w_win;
                r_we    <= w_win == OWN_CPU ? bus.cpu_we : (w_win == OWN_DSK && bus.dsk_we);
                r_be    <= w_win == OWN_CPU ? bus.cpu_sel : 2'b11;
                r_addr  <= w_win == OWN_VID ? bus.vid_addr :
                           w_win == OWN_DSK ? bus.dsk_addr : bus.cpu_addr;
                r_wdata <= w_win == OWN_CPU ? bus.cpu_wdata : bus.dsk_wdata;
            end
            if (r_state == RESP) r_owner <= OWN_NONE;
            if (r_state == WAIT && w_done) begin
                if (r_owner == OWN_VID) r_vid_rdata <= w_rdata;
                if (r_owner == OWN_DSK) r_dsk_rdata <= w_rdata;
                if (r_owner == OWN_CPU) r_cpu_rdata <= w_rdata;
            end
            // Burst length only counts unbroken disk demand; a CPU slot or an idle disk restarts it.
            if (r_state == IDLE)
                r_dsk_run <= (!bus.dsk_req || w_win == OWN_CPU) ? '0 :
                             (w_win == OWN_DSK && r_dsk_run != RUN_W'(DSK_BURST)) ? r_dsk_run + 1'b1 :
                             r_dsk_run;
        end
    end

    assign bus.owner     = r_owner;
    assign bus.mem_we    = r_we;
    assign bus.mem_be    = r_be;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.vid_rdata = r_vid_rdata;
    assign bus.dsk_rdata = r_dsk_rdata;
    assign bus.cpu_rdata = r_cpu_rdata;
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single SDRAM controller port between three requesters: video fetch, disk copy DMA (the dsk_copy path), and the CPU wishbone master.
- Sits between the existing memory-mapping logic and the SDRAM command engine.
- Owns priority, starvation control and the one-transaction-in-flight handshake.
- Replaces the current clock-gating scheme (CPU stalled whole while dsk_copy is active) with per-access arbitration.

Parameters:
- ADDR_W, 25, RAM word-address width.
- DSK_BURST, 8, maximum back-to-back disk grants before one CPU slot is forced if the CPU is waiting.
- TIMEOUT, 255, cycles to wait for mem_ack before abort (only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- vid_req  in  1  video fetch request (level, held until vid_ack).
- vid_addr  in  ADDR_W  video word address (read only).
- vid_ack  out  1  one-cycle pulse; vid_rdata valid.
- vid_rdata  out  16  video read data.
- dsk_req  in  1  disk copy request (level).
- dsk_we  in  1  disk write.
- dsk_addr  in  ADDR_W  disk word address.
- dsk_wdata  in  16  disk write data.
- dsk_ack  out  1  one-cycle pulse.
- dsk_rdata  out  16  disk read data.
- cpu_stb  in  1  CPU wishbone strobe, qualified by cyc and RAM select upstream.
- cpu_we  in  1  CPU write.
- cpu_sel  in  2  byte enables.
- cpu_addr  in  ADDR_W  mapped CPU word address.
- cpu_wdata  in  16  CPU write data.
- cpu_ack  out  1  one-cycle wishbone ack.
- cpu_rdata  out  16  CPU read data.
- mem_req  out  1  request to SDRAM engine.
- mem_we  out  1  write.
- mem_be  out  2  byte enables.
- mem_addr  out  ADDR_W  address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data.
- mem_ack  in  1  one-cycle completion from SDRAM engine.
- busy  out  1  transaction in flight.
- owner  out  2  current grant: 0 none, 1 vid, 2 dsk, 3 cpu.

Behaviour:
- Reset values: all outputs 0, including rdata buses; state IDLE; dsk_run 0.
- Single outstanding transaction. FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: sample requests and pick a winner.
  - Priority: vid > dsk > cpu.
  - Exception: if dsk_run == DSK_BURST and cpu_stb is high, the CPU wins over dsk (vid still first).
  - Register the winner's we/be/addr/wdata into mem_*; latch owner; go to ISSUE.
  - Video and disk always drive be=2'b11; video always drives we=0.
- ISSUE: mem_req=1 for exactly one cycle; go to WAIT.
- WAIT: hold mem_* stable. On mem_ack, capture mem_rdata into the owner's rdata register; go to RESP.
- RESP: pulse the owner's ack for one cycle; go to IDLE. Owner returns to 0 in IDLE.
  - Requester latency: grant → ack = 3 cycles + SDRAM latency.
  - The earliest next grant is the cycle after RESP.
- Requester obligation: hold req/stb until its ack. The arbiter does not re-sample the owner's inputs after grant.
- Requester dropping its request mid-transaction: the transaction still completes; the ack is still pulsed and may be ignored.
- dsk_run counter:
  - increments on each dsk grant, saturating at DSK_BURST;
  - clears on any cpu grant;
  - clears when a dsk_req is absent in IDLE.
- Video grants do not touch dsk_run.
- Simultaneous requests in the same IDLE cycle: exactly one grant. The others wait with their requests held; none is lost.
- mem_ack outside WAIT is ignored.
- Reset mid-transaction: return to IDLE next cycle; no ack is issued. The SDRAM engine is expected to be reset by the same signal.
- busy = state != IDLE.

Optional Feature:
- Macro: RAM_ARBITER_TIMEOUT_EN.
- With it defined:
  - a counter of width log2(TIMEOUT+1) runs in WAIT;
  - if it reaches TIMEOUT without mem_ack, go to RESP with the owner's rdata forced to 16'hFFFF;
  - a sticky output timeout_err (extra port, 1 bit, cleared only by reset) is set.
- Without it: WAIT waits indefinitely, and the timeout_err port and counter do not exist.

Decomposition:
- Package ram_arbiter_pkg:
  - owner encoding constants OWN_NONE/VID/DSK/CPU;
  - FSM state enum;
  - the ADDR_W default.
- One natural sub-module: ram_arbiter_pick, the combinational priority/starvation selector. Inputs: requests and dsk_run. Output: winner code.

Test Plan:
- Lone CPU read, addr 0x1000, mem_rdata 0x1234, mem_ack 2 cycles after mem_req → cpu_ack one pulse, cpu_rdata = 0x1234; owner 3 then 0; no vid/dsk ack.
- vid_req, dsk_req and cpu_stb asserted in the same cycle → grant order vid, dsk, cpu; exactly three mem_req pulses; each ack lands on the correct requester.
- dsk_req held continuously, cpu_stb held, DSK_BURST=8 → 8 dsk acks, then 1 cpu ack, then dsk resumes.
- CPU byte write, sel=2'b10, data 0xAB00 → mem_be=2'b10, mem_we=1, mem_wdata=0xAB00 stable from ISSUE through mem_ack.
- reset pulsed during WAIT → no ack pulses; busy=0 and owner=0 the next cycle; a following cpu request completes normally.
- With RAM_ARBITER_TIMEOUT_EN, TIMEOUT=16, mem_ack never arrives → cpu_ack 17–18 cycles after grant, cpu_rdata = 0xFFFF, timeout_err = 1 and stays set.
